// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: N_REQ packed request lanes plus one response channel.
interface adder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 3
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_cin;
  logic [N_REQ-1:0]    req_last;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [15:0]         rsp_sum;
  logic                rsp_cout;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 16-bit ripple-carry adder among N_REQ requesters.
// Define ADDER_ARB_CHAIN_EN to enable multi-word carry chaining with an owner lock.
module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_arbiter_if.slave    bus
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   next_ptr;
  logic             grant_found;
  logic             slot_free;
  logic             xfer;
  logic [N_REQ-1:0] grant;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic             op_cin;
  logic             op_last;
  logic             cin_eff;
  logic [16:0]      carry;
  logic [15:0]      sum;

  logic             rsp_valid_q;
  logic [15:0]      rsp_sum_q;
  logic             rsp_cout_q;
  logic [IDW-1:0]   rsp_id_q;

`ifdef ADDER_ARB_CHAIN_EN
  localparam logic [0:0] ST_FREE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]     lock_state;
  logic [IDW-1:0] owner;
  logic           carry_q;
`endif

  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  // Round-robin search: indices at or above the pointer win over wrapped ones.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
`ifdef ADDER_ARB_CHAIN_EN
    if (lock_state == ST_LOCKED) begin
      grant_idx = owner;
      for (int i = 0; i < N_REQ; i++) begin
        if (owner == IDW'(i)) grant_found = bus.req_valid[i];
      end
    end else begin
`else
    begin
`endif
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_found && (i >= int'(ptr)) && bus.req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = IDW'(i);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_found && (i < int'(ptr)) && bus.req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    grant   = '0;
    op_a    = '0;
    op_b    = '0;
    op_cin  = 1'b0;
    op_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant[i] = grant_found && slot_free && rst_n;
        op_a     = bus.req_a[16*i +: 16];
        op_b     = bus.req_b[16*i +: 16];
        op_cin   = bus.req_cin[i];
        op_last  = bus.req_last[i];
      end
    end
  end

  assign xfer          = |grant;
  assign bus.req_ready = grant;
  assign next_ptr      = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);

`ifdef ADDER_ARB_CHAIN_EN
  assign cin_eff = (lock_state == ST_LOCKED) ? carry_q : op_cin;
`else
  logic unused_last;
  assign unused_last = op_last;
  assign cin_eff     = op_cin;
`endif

  // Explicit ripple-carry chain, shared by every requester.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin_eff;
    for (int i = 0; i < 16; i++) begin
      sum[i]     = op_a[i] ^ op_b[i] ^ carry[i];
      carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      ptr         <= '0;
`ifdef ADDER_ARB_CHAIN_EN
      lock_state  <= ST_FREE;
      owner       <= '0;
      carry_q     <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        rsp_valid_q <= 1'b1;
        rsp_sum_q   <= sum;
        rsp_cout_q  <= carry[16];
        rsp_id_q    <= grant_idx;
`ifdef ADDER_ARB_CHAIN_EN
        carry_q <= carry[16];
        // The pointer only moves once a chain (or single-word op) completes.
        if (op_last) begin
          lock_state <= ST_FREE;
          ptr        <= next_ptr;
        end else begin
          lock_state <= ST_LOCKED;
          owner      <= grant_idx;
        end
`else
        ptr <= next_ptr;
`endif
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
`ifdef ADDER_ARB_CHAIN_EN
  assign bus.busy      = rsp_valid_q || (lock_state == ST_LOCKED);
`else
  assign bus.busy      = rsp_valid_q;
`endif

endmodule
